insmem: RTL and testbench

- Byte-addressed instruction memory for the RISC-V instruction-fetch stage. Holds 256 bytes.
- Returns the 32-bit little-endian word at a byte address combinationally, plus pre-decoded opcode and register fields.
- A synchronous word-write port loads programs.
- Reset restores a fixed boot image.

---
 rtl/insmem.sv | 65 ++++++
 tb/tb_insmem.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/insmem.sv
// Byte-addressed instruction memory with combinational fetch and field pre-decode.
// Reset loads a fixed boot image; a synchronous lane-masked word port loads programs.
module insmem #(
    parameter int ADDR_W   = 8,
    parameter bit INIT_NOP = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    output logic [31:0]       instruction,
    output logic [6:0]        ctrl,
    output logic [5:0]        rd,
    output logic [5:0]        rs1,
    output logic [5:0]        rs2,
    output logic              misaligned
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [31:0] FILL = INIT_NOP ? 32'h0000_0013 : 32'h0000_0000;

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] w_a1;
    logic [ADDR_W-1:0] w_a2;
    logic [ADDR_W-1:0] w_a3;

    function automatic logic [7:0] boot_byte(input int idx);
        logic [31:0] w;
        if (idx / 4 == 0)      w = 32'h0020_81B3;
        else if (idx / 4 == 1) w = 32'h4052_0233;
        else if (idx / 4 == 2) w = 32'h0062_F333;
        else                   w = FILL;
        return w[8*(idx%4) +: 8];
    endfunction

    // Lane i lands at waddr+i, wrapping at the top of the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= boot_byte(i);
            end
        end else if (we) begin
            for (int j = 0; j < 4; j++) begin
                if (wstrb[j]) begin
                    r_mem[waddr + ADDR_W'(j)] <= wdata[8*j +: 8];
                end
            end
        end
    end

    assign w_a1 = address + ADDR_W'(1);
    assign w_a2 = address + ADDR_W'(2);
    assign w_a3 = address + ADDR_W'(3);

    assign instruction = {r_mem[w_a3], r_mem[w_a2], r_mem[w_a1], r_mem[address]};
    assign ctrl        = instruction[6:0];
    assign rd          = {1'b0, instruction[11:7]};
    assign rs1         = {1'b0, instruction[19:15]};
    assign rs2         = {1'b0, instruction[24:20]};
    assign misaligned  = |address[1:0];

endmodule

// File: tb/tb_insmem.sv
// Self-checking bench for insmem: boot-image table, then write, wrap
// and reset sequences checked through an expected-result queue.
module tb_insmem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  address = 8'h00;
    logic        we = 1'b0;
    logic [7:0]  waddr = 8'h00;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] instruction;
    logic [6:0]  ctrl;
    logic [5:0]  rd;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic        misaligned;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] ins;
        logic [6:0]  ctrl;
        logic [5:0]  rd;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic        mis;
    } vec_t;

    vec_t sb[$];

    insmem #(.ADDR_W(8), .INIT_NOP(1'b0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .address(address),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .wstrb(wstrb),
        .instruction(instruction),
        .ctrl(ctrl),
        .rd(rd),
        .rs1(rs1),
        .rs2(rs2),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] a, input logic [31:0] ins);
        vec_t v;
        v.addr = a;
        v.ins  = ins;
        v.ctrl = ins[6:0];
        v.rd   = {1'b0, ins[11:7]};
        v.rs1  = {1'b0, ins[19:15]};
        v.rs2  = {1'b0, ins[24:20]};
        v.mis  = (a[1:0] != 2'b00);
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive the address, queue the expectation, then settle and compare.
    task automatic chk(input string nm, input vec_t v);
        vec_t e;
        address = v.addr;
        sb.push_back(v);
        #1;
        e = sb.pop_front();
        cmp({nm, ".ins"},  instruction,         e.ins);
        cmp({nm, ".ctrl"}, {25'd0, ctrl},       {25'd0, e.ctrl});
        cmp({nm, ".rd"},   {26'd0, rd},         {26'd0, e.rd});
        cmp({nm, ".rs1"},  {26'd0, rs1},        {26'd0, e.rs1});
        cmp({nm, ".rs2"},  {26'd0, rs2},        {26'd0, e.rs2});
        cmp({nm, ".mis"},  {31'd0, misaligned}, {31'd0, e.mis});
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        we = 1'b1;
        waddr = a;
        wdata = d;
        wstrb = s;
        @(posedge clk);
        #1;
        we = 1'b0;
        wstrb = 4'h0;
    endtask

    initial begin
        vec_t tbl[6];
        tbl[0] = '{8'h00, 32'h002081b3, 7'h33, 6'd3, 6'd1, 6'd2, 1'b0};
        tbl[1] = '{8'h04, 32'h40520233, 7'h33, 6'd4, 6'd4, 6'd5, 1'b0};
        tbl[2] = '{8'h08, 32'h0062f333, 7'h33, 6'd6, 6'd5, 6'd6, 1'b0};
        tbl[3] = '{8'h01, 32'h33002081, 7'h01, 6'd1, 6'd0, 6'd16, 1'b1};
        tbl[4] = '{8'h0c, 32'h00000000, 7'h00, 6'd0, 6'd0, 6'd0, 1'b0};
        tbl[5] = '{8'hfe, 32'h81b30000, 7'h00, 6'd0, 6'd6, 6'd27, 1'b1};

        #12;
        chk("rst_low", tbl[0]);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("boot%0d", i), tbl[i]);
        end

        // Read-during-write: old value before the edge, new one after.
        @(negedge clk);
        we = 1'b1;
        waddr = 8'h10;
        wdata = 32'h00a00093;
        wstrb = 4'hf;
        chk("rdw_pre", mk(8'h10, 32'h00000000));
        @(posedge clk);
        chk("rdw_post", '{8'h10, 32'h00a00093, 7'h13, 6'd1, 6'd0, 6'd10, 1'b0});
        we = 1'b0;
        wstrb = 4'h0;

        wr(8'h10, 32'hffffffff, 4'b0001);
        chk("lane0", mk(8'h10, 32'h00a000ff));

        wr(8'h20, 32'hffffffff, 4'b0000);
        chk("nostrb", mk(8'h20, 32'h00000000));

        wr(8'h30, 32'haabbccdd, 4'b1010);
        chk("lane13", mk(8'h30, 32'haa00cc00));

        wr(8'hfe, 32'h11223344, 4'hf);
        chk("wrap_fe", mk(8'hfe, 32'h11223344));
        chk("wrap_00", mk(8'h00, 32'h00201122));

        wr(8'h00, 32'hdeadbeef, 4'hf);
        chk("wr_00", mk(8'h00, 32'hdeadbeef));

        // Asynchronous reset between edges restores the image at once.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        chk("arst_00", tbl[0]);
        chk("arst_fe", tbl[5]);
        chk("arst_10", mk(8'h10, 32'h00000000));

        @(negedge clk);
        we = 1'b1;
        waddr = 8'h40;
        wdata = 32'h12345678;
        wstrb = 4'hf;
        @(posedge clk);
        chk("rst_wr", mk(8'h40, 32'h00000000));
        @(negedge clk);
        we = 1'b0;
        wstrb = 4'h0;
        rst_n = 1'b1;
        @(posedge clk);
        chk("post_rst40", mk(8'h40, 32'h00000000));
        chk("post_rst01", tbl[3]);
        chk("post_rst08", tbl[2]);

        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
